// File: rtl/wam_game_core.sv
// wam_game_core: whack-a-mole engine with LFSR mole, scoring, lockout and timer.
// Define WAM_HISCORE_EN to add the hi_score / new_record outputs.
module wam_game_core #(
    parameter int          N_HOLES      = 8,
    parameter int          POS_W        = 3,
    parameter int          SCORE_W      = 8,
    parameter int          TIME_W       = 5,
    parameter int          GAME_SECONDS = 20,
    parameter int          TICK_CYCLES  = 100000,
    parameter int          MOLE_CYCLES  = 25000,
    parameter int          LOCK_CYCLES  = 5000,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               restart_game,
    input  logic [POS_W-1:0]   user_guess,
    input  logic               eval_now,
    output logic [POS_W-1:0]   mole_pos,
    output logic               mole_change,
    output logic               guess_now,
    output logic               guess_correct,
    output logic               guess_wrong,
    output logic [SCORE_W-1:0] score,
    output logic [TIME_W-1:0]  seconds,
    output logic               game_over,
    output logic [N_HOLES-1:0] led
`ifdef WAM_HISCORE_EN
    ,
    output logic [SCORE_W-1:0] hi_score,
    output logic               new_record
`endif
);
    localparam int TICK_W = $clog2(TICK_CYCLES + 1);
    localparam int MOLE_W = $clog2(MOLE_CYCLES + 1);
    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
    localparam logic [MOLE_W-1:0] MOLE_LAST = MOLE_W'(MOLE_CYCLES - 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [POS_W:0]    HOLES     = (POS_W+1)'(N_HOLES);
    localparam logic [TIME_W-1:0] SECS_INIT = TIME_W'(GAME_SECONDS);
    localparam logic [TIME_W-1:0] SECS_ONE  = TIME_W'(1);

    typedef enum logic [1:0] {PLAY, LOCK, OVER} state_t;

    state_t             state_q, state_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [MOLE_W-1:0]  mcnt_q, mcnt_d;
    logic [LOCK_W-1:0]  lock_q, lock_d;
    logic [POS_W-1:0]   mole_q, mole_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [TIME_W-1:0]  secs_q, secs_d;
    logic               chg_q, chg_d;
    logic               corr_q, corr_d;
    logic               wrong_q, wrong_d;
    logic [POS_W:0]     cand;
    logic [POS_W-1:0]   next_pos;
    logic               tick_exp, mole_exp, move;
`ifdef WAM_HISCORE_EN
    logic [SCORE_W-1:0] hi_q, hi_d;
    logic               rec_q, rec_d;
`endif

    // Fold the LFSR slice into range, then step past the current hole
    always_comb begin
        cand = {1'b0, lfsr_q[POS_W-1:0]};
        if (cand >= HOLES) cand = cand - HOLES;
        if (cand == {1'b0, mole_q})
            cand = (cand == HOLES - 1'b1) ? '0 : cand + 1'b1;
        next_pos = cand[POS_W-1:0];
    end

    always_comb begin
        state_d  = state_q;
        lfsr_d   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        tick_d   = tick_q;
        mcnt_d   = mcnt_q;
        lock_d   = lock_q;
        mole_d   = mole_q;
        score_d  = score_q;
        secs_d   = secs_q;
        chg_d    = 1'b0;
        corr_d   = 1'b0;
        wrong_d  = 1'b0;
        tick_exp = 1'b0;
        mole_exp = 1'b0;
        move     = 1'b0;
`ifdef WAM_HISCORE_EN
        hi_d     = hi_q;
        rec_d    = 1'b0;
`endif
        if (restart_game) begin
            state_d = PLAY;
            tick_d  = '0;
            mcnt_d  = '0;
            lock_d  = '0;
            mole_d  = '0;
            score_d = '0;
            secs_d  = SECS_INIT;
        end else if (state_q != OVER) begin
            tick_exp = (tick_q == TICK_LAST);
            tick_d   = tick_exp ? '0 : tick_q + 1'b1;
            if (tick_exp) secs_d = secs_q - 1'b1;
            // The final tick outranks both guesses and mole moves
            if (tick_exp && secs_q == SECS_ONE) begin
                state_d = OVER;
`ifdef WAM_HISCORE_EN
                if (score_q > hi_q) begin
                    hi_d  = score_q;
                    rec_d = 1'b1;
                end
`endif
            end else begin
                mole_exp = (mcnt_q == MOLE_LAST);
                mcnt_d   = mole_exp ? '0 : mcnt_q + 1'b1;
                move     = mole_exp;
                if (state_q == LOCK) begin
                    lock_d = lock_q + 1'b1;
                    if (lock_q == LOCK_LAST) begin
                        state_d = PLAY;
                        lock_d  = '0;
                    end
                end else if (eval_now) begin
                    if (user_guess == mole_q) begin
                        corr_d = 1'b1;
                        move   = 1'b1;
                        mcnt_d = '0;
                        if (score_q != {SCORE_W{1'b1}}) score_d = score_q + 1'b1;
                    end else begin
                        wrong_d = 1'b1;
                        state_d = LOCK;
                        lock_d  = '0;
                        if (score_q != '0) score_d = score_q - 1'b1;
                    end
                end
                if (move) begin
                    mole_d = next_pos;
                    chg_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PLAY;
            lfsr_q  <= LFSR_SEED;
            tick_q  <= '0;
            mcnt_q  <= '0;
            lock_q  <= '0;
            mole_q  <= '0;
            score_q <= '0;
            secs_q  <= SECS_INIT;
            chg_q   <= 1'b0;
            corr_q  <= 1'b0;
            wrong_q <= 1'b0;
`ifdef WAM_HISCORE_EN
            hi_q    <= '0;
            rec_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            tick_q  <= tick_d;
            mcnt_q  <= mcnt_d;
            lock_q  <= lock_d;
            mole_q  <= mole_d;
            score_q <= score_d;
            secs_q  <= secs_d;
            chg_q   <= chg_d;
            corr_q  <= corr_d;
            wrong_q <= wrong_d;
`ifdef WAM_HISCORE_EN
            hi_q    <= hi_d;
            rec_q   <= rec_d;
`endif
        end
    end

    assign mole_pos      = mole_q;
    assign mole_change   = chg_q;
    assign guess_now     = (state_q == PLAY);
    assign guess_correct = corr_q;
    assign guess_wrong   = wrong_q;
    assign score         = score_q;
    assign seconds       = secs_q;
    assign game_over     = (state_q == OVER);
    assign led           = (state_q == OVER) ? '0 : N_HOLES'(1) << mole_q;
`ifdef WAM_HISCORE_EN
    assign hi_score      = hi_q;
    assign new_record    = rec_q;
`endif
endmodule

// File: tb/tb_wam_game_core.sv
// Randomised and directed bench for wam_game_core against a behavioural model.
// Builds with or without WAM_HISCORE_EN.
module tb_wam_game_core;
    localparam int NH = 5, PW = 3, SW = 2, TW = 5, GS = 3;
    localparam int TICKS = 100, MOLE = 20, LOCK = 10;
    localparam int SMAX = (1 << SW) - 1;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0, rst = 1'b0, restart_game = 1'b0, eval_now = 1'b0;
    logic [PW-1:0] user_guess = '0;
    logic [PW-1:0] mole_pos;
    logic mole_change, guess_now, guess_correct, guess_wrong, game_over;
    logic [SW-1:0] score;
    logic [TW-1:0] seconds;
    logic [NH-1:0] led;
`ifdef WAM_HISCORE_EN
    logic [SW-1:0] hi_score;
    logic new_record;
`endif

    int n_vec = 0, n_err = 0;

    logic [15:0] m_lfsr;
    int m_pos, m_score, m_secs, m_tick, m_age, m_lock_left, m_hi;
    bit m_over, m_chg, m_corr, m_wrong, m_rec;

    wam_game_core #(
        .N_HOLES(NH), .POS_W(PW), .SCORE_W(SW), .TIME_W(TW),
        .GAME_SECONDS(GS), .TICK_CYCLES(TICKS), .MOLE_CYCLES(MOLE),
        .LOCK_CYCLES(LOCK), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .restart_game(restart_game),
        .user_guess(user_guess), .eval_now(eval_now),
        .mole_pos(mole_pos), .mole_change(mole_change),
        .guess_now(guess_now), .guess_correct(guess_correct),
        .guess_wrong(guess_wrong), .score(score), .seconds(seconds),
        .game_over(game_over), .led(led)
`ifdef WAM_HISCORE_EN
        , .hi_score(hi_score), .new_record(new_record)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(logic [15:0] s);
        logic [15:0] b;
        b = (s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 16'd1;
        return (s >> 1) | (b << 15);
    endfunction

    function automatic int pick_pos(logic [15:0] s, int old);
        int c;
        c = int'(s) % (1 << PW);
        if (c >= NH) c -= NH;
        if (c == old) c = (c + 1) % NH;
        return c;
    endfunction

    task automatic game_init();
        m_pos = 0; m_score = 0; m_secs = GS; m_tick = 0;
        m_age = 0; m_lock_left = 0; m_over = 0;
    endtask

    // One clock edge of game rules, applied to the model
    task automatic model_step(bit r, bit rs, int g, bit ev);
        logic [15:0] cur;
        bit moved;
        cur = m_lfsr;
        m_chg = 0; m_corr = 0; m_wrong = 0; m_rec = 0;
        if (r) begin
            m_lfsr = SEED; game_init(); m_hi = 0;
            return;
        end
        m_lfsr = lfsr_next(cur);
        if (rs) begin
            game_init();
            return;
        end
        if (m_over) return;
        m_tick++;
        if (m_tick == TICKS) begin
            m_tick = 0;
            m_secs--;
            if (m_secs == 0) begin
                m_over = 1;
                if (m_score > m_hi) begin
                    m_hi = m_score; m_rec = 1;
                end
                return;
            end
        end
        m_age++;
        moved = (m_age == MOLE);
        if (m_lock_left > 0) m_lock_left--;
        else if (ev) begin
            if (g == m_pos) begin
                m_corr = 1; moved = 1;
                if (m_score < SMAX) m_score++;
            end else begin
                m_wrong = 1; m_lock_left = LOCK;
                if (m_score > 0) m_score--;
            end
        end
        if (moved) begin
            m_pos = pick_pos(cur, m_pos);
            m_chg = 1; m_age = 0;
        end
    endtask

    function automatic logic [31:0] exp_vec();
        logic [NH-1:0] l;
        logic gn;
        logic [31:0] v;
        l = m_over ? '0 : NH'(1 << m_pos);
        gn = !m_over && (m_lock_left == 0);
        v = 32'({PW'(m_pos), m_chg, gn, m_corr, m_wrong,
                 SW'(m_score), TW'(m_secs), m_over, l});
`ifdef WAM_HISCORE_EN
        v = (v << 3) | 32'({SW'(m_hi), m_rec});
`endif
        return v;
    endfunction

    function automatic logic [31:0] obs_vec();
        logic [31:0] v;
        v = 32'({mole_pos, mole_change, guess_now, guess_correct, guess_wrong,
                 score, seconds, game_over, led});
`ifdef WAM_HISCORE_EN
        v = (v << 3) | 32'({hi_score, new_record});
`endif
        return v;
    endfunction

    task automatic step(bit r, bit rs, int g, bit ev);
        rst = r; restart_game = rs; user_guess = PW'(g); eval_now = ev;
        @(posedge clk);
        model_step(r, rs, g, ev);
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        n_vec++;
        if ({mole_pos, led, score, seconds, game_over, guess_now,
             mole_change, guess_correct, guess_wrong} !==
            {3'd0, 5'b00001, 2'd0, 5'd3, 1'b0, 1'b1, 3'b000}) begin
            n_err++;
            $display("FAIL reset: pos=%0d led=%b sc=%0d sec=%0d go=%b gn=%b", mole_pos,
                     led, score, seconds, game_over, guess_now);
        end
        n_vec++;
        if (obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL reset_model: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_idle();
        logic [PW-1:0] prev;
        prev = mole_pos;
        for (int i = 1; i <= 300; i++) begin
            step(0, 0, 0, 0);
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL idle_model cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            n_vec++;
            if (mole_change !== (i % 20 == 0 && i < 300) || mole_pos >= NH ||
                (mole_change && mole_pos == prev)) begin
                n_err++;
                $display("FAIL idle_move cyc %0d: chg=%b pos=%0d prev=%0d", i,
                         mole_change, mole_pos, prev);
            end
            prev = mole_pos;
            if (i == 100 || i == 200 || i == 300) begin
                n_vec++;
                if (seconds !== TW'(3 - i / 100) || game_over !== (i == 300) ||
                    (i == 300 && led !== '0)) begin
                    n_err++;
                    $display("FAIL idle_timer cyc %0d: sec=%0d go=%b led=%b", i,
                             seconds, game_over, led);
                end
            end
        end
    endtask

    task automatic test_over_eval(int sc);
        logic [PW-1:0] frozen;
        frozen = mole_pos;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, m_pos, 1);
            n_vec++;
            if (guess_correct || guess_wrong || score !== SW'(sc) || !game_over ||
                led !== '0 || mole_pos !== frozen || seconds !== '0 || guess_now) begin
                n_err++;
                $display("FAIL over_eval: c=%b w=%b sc=%0d go=%b pos=%0d sec=%0d",
                         guess_correct, guess_wrong, score, game_over, mole_pos, seconds);
            end
        end
    endtask

    task automatic test_restart();
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 1);
            n_vec++;
            if (score !== '0 || seconds !== 5'd3 || game_over || !guess_now ||
                guess_correct || guess_wrong || mole_change) begin
                n_err++;
                $display("FAIL restart_hold: sc=%0d sec=%0d go=%b gn=%b", score,
                         seconds, game_over, guess_now);
            end
        end
        step(0, 0, 0, 0);
        n_vec++;
        if (score !== '0 || seconds !== 5'd3 || game_over || !guess_now ||
            obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL restart_release: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_correct();
        int old;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        old = m_pos;
        step(0, 0, old, 1);
        n_vec++;
        if (!guess_correct || guess_wrong || score !== 2'd1 || !mole_change ||
            mole_pos == PW'(old) || obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL correct: c=%b sc=%0d chg=%b pos=%0d old=%0d", guess_correct,
                     score, mole_change, mole_pos, old);
        end
        for (int k = 1; k <= 20; k++) begin
            step(0, 0, 0, 0);
            n_vec++;
            if (mole_change !== (k == 20) || obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL correct_rearm k=%0d: chg=%b got %h want %h", k,
                         mole_change, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_wrong();
        step(0, 0, (m_pos + 1) % NH, 1);
        n_vec++;
        if (!guess_wrong || guess_correct || score !== '0 || guess_now) begin
            n_err++;
            $display("FAIL wrong_at1: w=%b sc=%0d gn=%b", guess_wrong, score, guess_now);
        end
        for (int k = 1; k <= 10; k++) begin
            step(0, 0, m_pos, k == 5);
            n_vec++;
            if (guess_now !== (k == 10) || guess_correct || guess_wrong ||
                score !== '0 || obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL lockout k=%0d: gn=%b c=%b w=%b sc=%0d", k, guess_now,
                         guess_correct, guess_wrong, score);
            end
        end
        step(0, 0, (m_pos + 1) % NH, 1);
        n_vec++;
        if (!guess_wrong || score !== '0) begin
            n_err++;
            $display("FAIL wrong_at0: w=%b sc=%0d", guess_wrong, score);
        end
        for (int k = 0; k < 10; k++) step(0, 0, 0, 0);
        step(0, 0, 7, 1);
        n_vec++;
        if (!guess_wrong || guess_correct || obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL guess7: w=%b c=%b got %h want %h", guess_wrong,
                     guess_correct, obs_vec(), exp_vec());
        end
        for (int k = 0; k < 10; k++) step(0, 0, 0, 0);
    endtask

    task automatic test_saturate();
        int want;
        step(0, 1, 0, 0);
        for (int j = 0; j < 5; j++) begin
            step(0, 0, 0, 0);
            step(0, 0, m_pos, 1);
            want = (j < 2) ? j + 1 : 3;
            n_vec++;
            if (!guess_correct || score !== SW'(want)) begin
                n_err++;
                $display("FAIL saturate #%0d: c=%b sc=%0d want %0d", j, guess_correct,
                         score, want);
            end
        end
    endtask

    task automatic test_final_tick();
        bit found;
        int sc;
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (!m_over && m_secs == 1 && m_tick == TICKS - 1) found = 1;
            else step(0, 0, 0, 0);
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL final_tick: last second never reached, sec=%0d", seconds);
            return;
        end
        sc = m_score;
        step(0, 0, m_pos, 1);
        n_vec++;
        if (!game_over || guess_correct || guess_wrong || score !== SW'(sc) ||
            seconds !== '0 || obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL final_tick_eval: go=%b c=%b w=%b sc=%0d sec=%0d", game_over,
                     guess_correct, guess_wrong, score, seconds);
        end
        test_over_eval(sc);
    endtask

`ifdef WAM_HISCORE_EN
    task automatic play_to_over(int hits, int want_hi, bit want_rec);
        step(0, 1, 0, 0);
        for (int j = 0; j < hits; j++) step(0, 0, m_pos, 1);
        for (int i = 0; i < 400 && !m_over; i++) step(0, 0, 0, 0);
        n_vec++;
        if (!game_over || hi_score !== SW'(want_hi) || new_record !== want_rec) begin
            n_err++;
            $display("FAIL hiscore_end: go=%b hi=%0d rec=%b want %0d/%b", game_over,
                     hi_score, new_record, want_hi, want_rec);
        end
        step(0, 0, 0, 0);
        n_vec++;
        if (new_record || hi_score !== SW'(want_hi)) begin
            n_err++;
            $display("FAIL hiscore_pulse: rec=%b hi=%0d", new_record, hi_score);
        end
    endtask

    task automatic test_hiscore();
        step(1, 0, 0, 0);
        play_to_over(2, 2, 1);
        play_to_over(1, 2, 0);
        step(1, 0, 0, 0);
        n_vec++;
        if (hi_score !== '0 || new_record) begin
            n_err++;
            $display("FAIL hiscore_rst: hi=%0d rec=%b", hi_score, new_record);
        end
    endtask
`endif

    task automatic test_random();
        int r, g;
        step(1, 0, 0, 0);
        for (int i = 0; i < 1200; i++) begin
            r = int'($urandom_range(0, 9));
            g = (r < 5) ? m_pos : (r < 8) ? int'($urandom_range(0, NH - 1))
                                          : int'($urandom_range(NH, 7));
            step(0, $urandom_range(0, 119) == 0, g, $urandom_range(0, 3) == 0);
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL random cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_over_eval(0);
        test_restart();
        test_correct();
        test_wrong();
        test_saturate();
        test_final_tick();
`ifdef WAM_HISCORE_EN
        test_hiscore();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/wam_game_core.md
Name: wam_game_core

Overview:
- Parametrised whack-a-mole game engine: LFSR-driven mole placement, guess evaluation, wrong-guess lockout, saturating score, countdown timer, game-over handling.
- Next generation of the fixed 8-hole, 3-bit-guess core. Adds:
  - configurable hole count and widths;
  - score penalty on a wrong guess;
  - guaranteed mole movement;
  - explicit simultaneous-event priority.
- Sits between the debounced button/switch front end (`eval_now`, `user_guess`) and the LED/7-segment display drivers.

Parameters:
- N_HOLES, 8, number of holes/LEDs; 2..16; must satisfy 2*N_HOLES >= 2**POS_W.
- POS_W, 3, width of mole_pos/user_guess.
- SCORE_W, 8, score width.
- TIME_W, 5, seconds width.
- GAME_SECONDS, 20, game length in ticks; must be < 2**TIME_W.
- TICK_CYCLES, 100000, clk cycles per game second.
- MOLE_CYCLES, 25000, clk cycles between automatic mole moves.
- LOCK_CYCLES, 5000, lockout length after a wrong guess.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- restart_game  in  1  level; re-initialises the game while high
- user_guess  in  POS_W  guessed hole index
- eval_now  in  1  one-cycle pulse; evaluate user_guess
- mole_pos  out  POS_W  current mole hole, always < N_HOLES
- mole_change  out  1  one-cycle pulse, same cycle mole_pos takes a new value
- guess_now  out  1  high when eval_now will be accepted
- guess_correct  out  1  one-cycle pulse
- guess_wrong  out  1  one-cycle pulse
- score  out  SCORE_W  current score
- seconds  out  TIME_W  seconds remaining
- game_over  out  1  high in OVER
- led  out  N_HOLES  one-hot of mole_pos in PLAY/LOCK; all zero in OVER

Behaviour:
- Single clock domain, clk. rst is synchronous, active-high, and overrides everything.
- Reset values:
  - state PLAY; mole_pos 0; led 1; score 0; seconds GAME_SECONDS;
  - game_over 0; guess_now 1; all pulse outputs 0;
  - LFSR = LFSR_SEED; tick, mole and lock counters 0.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11; advances every cycle in every state.
  - Only rst reseeds it; restart_game does not.
- New-position rule:
  - c = lfsr[POS_W-1:0]; if c >= N_HOLES then c -= N_HOLES.
  - If c == mole_pos then c = (c+1) mod N_HOLES.
  - Result: mole always moves and is always in range.
- States:
  - PLAY (guess_now=1):
    - Tick counter wraps at TICK_CYCLES-1 and decrements seconds.
    - Mole counter wraps at MOLE_CYCLES-1 and moves the mole (mole_change=1).
  - LOCK (guess_now=0):
    - Entered on a wrong guess. Lock counter runs LOCK_CYCLES cycles, then returns to PLAY.
    - Timer and mole keep running.
    - eval_now is ignored: no pulse, no score change.
  - OVER (game_over=1, guess_now=0):
    - Entered from PLAY or LOCK when seconds decrements to 0.
    - mole_pos frozen, led=0, eval_now ignored, seconds held at 0.
- Guess evaluation (PLAY only, eval_now=1):
  - Result registered; pulse appears the cycle after eval_now is sampled. score updates in the same cycle as the pulse.
  - Correct (user_guess==mole_pos):
    - guess_correct=1; score +1, saturating at 2**SCORE_W-1.
    - Mole moves immediately (mole_change=1) and the mole counter clears.
  - Wrong:
    - guess_wrong=1; score -1, saturating at 0.
    - Enter LOCK.
  - user_guess >= N_HOLES is always wrong.
- Priority within one cycle, highest first:
  1. rst
  2. restart_game
  3. final tick (seconds 1→0): eval_now in the same cycle is ignored
  4. eval_now
  5. mole counter expiry
- eval_now coinciding with mole expiry:
  - Compared against the pre-update mole_pos.
  - Exactly one move occurs.
  - The mole counter clears.
- restart_game:
  - While high, every cycle forces the reset values except the LFSR. The game is frozen.
  - PLAY begins on the first cycle after it drops.
  - Legal mid-LOCK or mid-OVER; no pulses are generated.

Optional Feature:
- Macro WAM_HISCORE_EN.
- Defined:
  - Adds ports hi_score (out, SCORE_W) and new_record (out, 1).
  - On the cycle OVER is entered: if score > hi_score, then hi_score <= score and new_record pulses for 1 cycle.
  - hi_score resets to 0 on rst only; it is kept across restart_game.
- Undefined: both ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Bench params: TICK_CYCLES=100, MOLE_CYCLES=20, LOCK_CYCLES=10, GAME_SECONDS=3, N_HOLES=5, POS_W=3.
- Idle run after rst, no input:
  - mole_change every 20 cycles; mole_pos always in 0..4 and always differs from its previous value.
  - seconds 3→2→1→0 at cycles 100/200/300; game_over=1 at cycle 300; led=0.
- Correct guess (eval_now pulse, user_guess=mole_pos):
  - Next cycle: guess_correct=1, score 0→1, mole_change=1, new mole_pos ≠ old.
  - Next auto move 20 cycles later.
- Wrong guess at score 1 (user_guess=mole_pos+1 mod 5):
  - guess_wrong=1, score→0, guess_now=0 for 10 cycles.
  - Correct eval_now 5 cycles later: no pulse, score stays 0.
  - Wrong guess at score 0: score stays 0. user_guess=7: guess_wrong.
- Edge coincidences:
  - eval_now on the cycle seconds goes 1→0: no pulse, game_over=1.
  - eval_now in OVER: ignored.
  - restart_game held 3 cycles: score 0, seconds 3, game_over 0 and guess_now 1 after release.
- SCORE_W=2 with 5 correct guesses: score 1,2,3,3,3.
- With WAM_HISCORE_EN:
  - Game ending at score 2: hi_score=2, new_record pulses.
  - Next game ending at 1: hi_score stays 2, no pulse.
  - rst: hi_score=0.
